ssd_scan_decoder: RTL and testbench



---
 rtl/ssd_scan_decoder.sv | 148 ++++++++++++++
 tb/tb_ssd_scan_decoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_decoder.sv
// rtl/ssd_scan_decoder.sv - scan-bus monitor rebuilding displayed MM:SS as BCD (option: SSD_SCAN_RANGE_CHECK_EN)
module ssd_scan_decoder #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] seven_segment_display_i,
    output logic [7:0]  min_o,
    output logic [7:0]  sec_o,
    output logic        frame_valid_o,
    output logic        glyph_err_o,
    output logic        display_dead_o,
    output logic [3:0]  seen_o
);
    localparam int SW = $clog2(STABLE_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {HUNT, QUALIFY, ACCEPT, HOLD} state_t;

    state_t          state;
    logic [10:0]     smp;
    logic [10:0]     cand;
    logic [SW-1:0]   stable_cnt;
    logic [TW-1:0]   idle_cnt;
    logic [3:0][3:0] shadow;

    logic       smp_valid;
    logic [4:0] dec;
    logic [1:0] idx;
    logic       legal;
    logic       publish;
    logic [3:0] seen_base;

    // Returns {legal, value} for an active-low a..g glyph.
    function automatic logic [4:0] decode(input logic [6:0] g);
        case (g)
            7'b0000001: decode = {1'b1, 4'd0};
            7'b1001111: decode = {1'b1, 4'd1};
            7'b0010010: decode = {1'b1, 4'd2};
            7'b0000110: decode = {1'b1, 4'd3};
            7'b1001100: decode = {1'b1, 4'd4};
            7'b0100100: decode = {1'b1, 4'd5};
            7'b0100000: decode = {1'b1, 4'd6};
            7'b0001111: decode = {1'b1, 4'd7};
            7'b0000000: decode = {1'b1, 4'd8};
            7'b0000100: decode = {1'b1, 4'd9};
            default:    decode = 5'd0;
        endcase
    endfunction

    always_comb begin
        smp_valid = 1'b0;
        case (smp[10:7])
            4'b0111, 4'b1011, 4'b1101, 4'b1110: smp_valid = 1'b1;
            default:                            smp_valid = 1'b0;
        endcase
    end

    // Candidate anode is always one-hot-low by construction, so idx is exact.
    always_comb begin
        idx = 2'd0;
        case (cand[10:7])
            4'b0111: idx = 2'd3;
            4'b1011: idx = 2'd2;
            4'b1101: idx = 2'd1;
            default: idx = 2'd0;
        endcase
        dec   = decode(cand[6:0]);
        legal = dec[4];
`ifdef SSD_SCAN_RANGE_CHECK_EN
        if ((idx == 2'd3 || idx == 2'd1) && dec[3:0] > 4'd5)
            legal = 1'b0;
`endif
        publish   = (seen_o == 4'b1111);
        seen_base = publish ? 4'b0000 : seen_o;
    end

    assign display_dead_o = (idle_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= HUNT;
            smp           <= '1;
            cand          <= '1;
            stable_cnt    <= '0;
            idle_cnt      <= '0;
            shadow        <= '0;
            seen_o        <= '0;
            min_o         <= '0;
            sec_o         <= '0;
            frame_valid_o <= 1'b0;
            glyph_err_o   <= 1'b0;
        end else begin
            smp           <= seven_segment_display_i;
            frame_valid_o <= 1'b0;
            glyph_err_o   <= 1'b0;
            if (idle_cnt != TW'(TIMEOUT_CYCLES))
                idle_cnt <= idle_cnt + 1'b1;

            if (publish) begin
                min_o         <= {shadow[3], shadow[2]};
                sec_o         <= {shadow[1], shadow[0]};
                frame_valid_o <= 1'b1;
                seen_o        <= 4'b0000;
            end

            case (state)
                HUNT: begin
                    if (smp_valid) begin
                        cand       <= smp;
                        stable_cnt <= SW'(1);
                        state      <= QUALIFY;
                    end
                end
                QUALIFY: begin
                    if (smp == cand) begin
                        stable_cnt <= stable_cnt + 1'b1;
                        if (stable_cnt + 1'b1 == SW'(STABLE_CYCLES))
                            state <= ACCEPT;
                    end else if (smp_valid) begin
                        cand       <= smp;
                        stable_cnt <= SW'(1);
                    end else begin
                        stable_cnt <= '0;
                        state      <= HUNT;
                    end
                end
                ACCEPT: begin
                    idle_cnt   <= '0;
                    stable_cnt <= '0;
                    if (legal) begin
                        shadow[idx] <= dec[3:0];
                        seen_o      <= seen_base | (4'b0001 << idx);
                    end else begin
                        glyph_err_o <= 1'b1;
                    end
                    state <= HOLD;
                end
                HOLD: begin
                    if (smp != cand)
                        state <= HUNT;
                end
                default: state <= HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb/tb_ssd_scan_decoder.sv - self-checking bench for ssd_scan_decoder
module tb_ssd_scan_decoder;
    localparam int STABLE  = 16;
    localparam int TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] bus = '1;
    logic [7:0]  min_o, sec_o;
    logic        frame_valid_o, glyph_err_o, display_dead_o;
    logic [3:0]  seen_o;

    ssd_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .seven_segment_display_i(bus),
        .min_o(min_o), .sec_o(sec_o), .frame_valid_o(frame_valid_o),
        .glyph_err_o(glyph_err_o), .display_dead_o(display_dead_o), .seen_o(seen_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int err_cnt = 0;
    logic [15:0] frames[$];
    logic [6:0] seg_of [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_valid_o) begin
                fv_cnt++;
                frames.push_back({min_o, sec_o});
            end
            if (glyph_err_o) err_cnt++;
        end
    end

    function automatic logic [10:0] word(input int idx, input logic [6:0] g);
        logic [3:0] an;
        an = ~(4'b0001 << idx);
        return {an, g};
    endfunction

    // Model of what one stable presentation means on a given digit position.
    function automatic bit accepts(input int idx, input logic [6:0] g, output int v);
        v = -1;
        for (int i = 0; i < 10; i++) if (seg_of[i] == g) v = i;
        if (v < 0) return 1'b0;
`ifdef SSD_SCAN_RANGE_CHECK_EN
        if ((idx == 3 || idx == 1) && v > 5) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic hold(input logic [10:0] v, input int n);
        bus = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input int idx, input int d, input int n);
        hold(word(idx, seg_of[d]), n);
        hold(11'h7FF, 2);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        bus = '1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (min_o !== 8'h00) begin errors++; $display("FAIL reset_min: got %h expected 00", min_o); end
        checks++; if (sec_o !== 8'h00) begin errors++; $display("FAIL reset_sec: got %h expected 00", sec_o); end
        checks++; if (seen_o !== 4'h0) begin errors++; $display("FAIL reset_seen: got %h expected 0", seen_o); end
        checks++; if ({frame_valid_o, glyph_err_o, display_dead_o} !== 3'b000)
            begin errors++; $display("FAIL reset_flags: got %b expected 000", {frame_valid_o, glyph_err_o, display_dead_o}); end
    endtask

    task automatic test_sweep;
        int fv0 = fv_cnt, e0 = err_cnt, b = frames.size();
        for (int s = 0; s < 2; s++) begin
            show(3, 1, 32); show(2, 0, 32); show(1, 5, 32); show(0, 9, 32);
        end
        hold(11'h7FF, 3);
        checks++; if (fv_cnt - fv0 !== 2) begin errors++; $display("FAIL sweep_frames: got %0d expected 2", fv_cnt - fv0); end
        checks++; if (min_o !== 8'h10) begin errors++; $display("FAIL sweep_min: got %h expected 10", min_o); end
        checks++; if (sec_o !== 8'h59) begin errors++; $display("FAIL sweep_sec: got %h expected 59", sec_o); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL sweep_err: got %0d expected 0", err_cnt - e0); end
        checks++; if (frames.size() < b + 1 || frames[b] !== 16'h1059)
            begin errors++; $display("FAIL sweep_first_frame: got %0d frames expected first 1059", frames.size() - b); end
    endtask

    task automatic test_bounce;
        int fv0 = fv_cnt, e0 = err_cnt;
        hold(word(0, seg_of[3]), 5);
        hold(word(0, seg_of[8]), 1);
        checks++; if (seen_o !== 4'b0000) begin errors++; $display("FAIL bounce_early: got %b expected 0000", seen_o); end
        hold(word(0, seg_of[3]), 20);
        hold(11'h7FF, 2);
        checks++; if (seen_o !== 4'b0001) begin errors++; $display("FAIL bounce_seen: got %b expected 0001", seen_o); end
        show(3, 1, 24); show(2, 2, 24); show(1, 4, 24);
        hold(11'h7FF, 2);
        checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL bounce_frames: got %0d expected 1", fv_cnt - fv0); end
        checks++; if ({min_o, sec_o} !== 16'h1243) begin errors++; $display("FAIL bounce_value: got %h expected 1243", {min_o, sec_o}); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL bounce_err: got %0d expected 0", err_cnt - e0); end
    endtask

    task automatic test_illegal;
        int fv0 = fv_cnt, e0 = err_cnt;
        hold(word(2, 7'b1111110), 20);
        hold(11'h7FF, 2);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL illegal_err: got %0d expected 1", err_cnt - e0); end
        checks++; if (seen_o[2] !== 1'b0) begin errors++; $display("FAIL illegal_seen: got %b expected 0", seen_o[2]); end
        checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL illegal_frame: got %0d expected 0", fv_cnt - fv0); end
    endtask

    task automatic test_multi_anode;
        int fv0 = fv_cnt, e0 = err_cnt;
        hold({4'b0011, seg_of[5]}, 100);
        hold(11'h7FF, 2);
        checks++; if (seen_o !== 4'b0000) begin errors++; $display("FAIL multi_seen: got %b expected 0000", seen_o); end
        checks++; if (err_cnt - e0 + fv_cnt - fv0 !== 0) begin errors++; $display("FAIL multi_events: got %0d expected 0", err_cnt - e0 + fv_cnt - fv0); end
    endtask

    task automatic test_timeout;
        bit done = 0;
        do_reset();
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        checks++; if (display_dead_o !== 1'b0) begin errors++; $display("FAIL dead_early: got %b expected 0", display_dead_o); end
        @(posedge clk); #1;
        checks++; if (display_dead_o !== 1'b1) begin errors++; $display("FAIL dead_rise: got %b expected 1", display_dead_o); end
        repeat (30) @(posedge clk);
        #1;
        checks++; if (display_dead_o !== 1'b1) begin errors++; $display("FAIL dead_hold: got %b expected 1", display_dead_o); end
        bus = word(0, seg_of[7]);
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk); #1;
            if (!display_dead_o) begin
                done = 1;
                checks++; if (seen_o !== 4'b0001) begin errors++; $display("FAIL dead_clear_seen: got %b expected 0001", seen_o); end
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL dead_clear: got 1 expected 0 within 60 cycles"); end
        hold(11'h7FF, 2);
    endtask

    task automatic test_reset_mid;
        do_reset();
        show(3, 2, 24); show(2, 3, 24); show(1, 4, 24); show(0, 5, 24);
        checks++; if ({min_o, sec_o} !== 16'h2345) begin errors++; $display("FAIL mid_pre_frame: got %h expected 2345", {min_o, sec_o}); end
        show(3, 1, 24); show(2, 2, 24); show(1, 3, 24);
        checks++; if (seen_o !== 4'b1110) begin errors++; $display("FAIL mid_partial: got %b expected 1110", seen_o); end
        do_reset();
        checks++; if ({seen_o, min_o, sec_o} !== 20'h0) begin errors++; $display("FAIL mid_cleared: got %h expected 00000", {seen_o, min_o, sec_o}); end
        show(3, 0, 24); show(2, 1, 24); show(1, 5, 24); show(0, 8, 24);
        checks++; if ({min_o, sec_o} !== 16'h0158) begin errors++; $display("FAIL mid_after: got %h expected 0158", {min_o, sec_o}); end
    endtask

    task automatic test_range;
        int e0;
        do_reset();
        e0 = err_cnt;
        show(1, 7, 24);
`ifdef SSD_SCAN_RANGE_CHECK_EN
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL range_err: got %0d expected 1", err_cnt - e0); end
        checks++; if (seen_o[1] !== 1'b0) begin errors++; $display("FAIL range_seen: got %b expected 0", seen_o[1]); end
`else
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL range_err: got %0d expected 0", err_cnt - e0); end
        checks++; if (seen_o[1] !== 1'b1) begin errors++; $display("FAIL range_seen: got %b expected 1", seen_o[1]); end
`endif
    endtask

    task automatic test_random;
        logic [3:0]  sh [4];
        logic [3:0]  mseen = 4'b0;
        logic [15:0] exp_q[$];
        logic [6:0]  g;
        int exp_err = 0, idx, n, v, e0, f0, b;
        do_reset();
        e0 = err_cnt; f0 = fv_cnt; b = frames.size();
        for (int k = 0; k < 4; k++) sh[k] = 4'h0;
        for (int t = 0; t < 60; t++) begin
            idx = $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) g = 7'($urandom);
            else g = seg_of[$urandom_range(0, 9)];
            n = $urandom_range(STABLE - 3, STABLE + 8);
            hold(word(idx, g), n);
            hold(11'h7FF, 2);
            if (n >= STABLE) begin
                if (accepts(idx, g, v)) begin
                    sh[idx] = 4'(v);
                    mseen[idx] = 1'b1;
                    if (mseen == 4'hF) begin
                        exp_q.push_back({sh[3], sh[2], sh[1], sh[0]});
                        mseen = 4'h0;
                    end
                end else begin
                    exp_err++;
                end
            end
        end
        hold(11'h7FF, 3);
        checks++; if (fv_cnt - f0 !== exp_q.size()) begin errors++; $display("FAIL rand_frames: got %0d expected %0d", fv_cnt - f0, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && b + i < frames.size(); i++) begin
            checks++; if (frames[b + i] !== exp_q[i]) begin errors++; $display("FAIL rand_frame%0d: got %h expected %h", i, frames[b + i], exp_q[i]); end
        end
        checks++; if (err_cnt - e0 !== exp_err) begin errors++; $display("FAIL rand_err: got %0d expected %0d", err_cnt - e0, exp_err); end
        checks++; if (seen_o !== mseen) begin errors++; $display("FAIL rand_seen: got %b expected %b", seen_o, mseen); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_sweep();
        test_bounce();
        test_illegal();
        test_multi_anode();
        test_timeout();
        test_reset_mid();
        test_range();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
